// File: rtl/systolic_gemm_engine.sv
// -----------------------------------------------------------------------------
// systolic_gemm_engine
//
// Output-stationary R x C systolic multiply-accumulate array computing one
// result tile C = A * B (A is R x n, B is n x C) for a runtime inner dimension
// n <= N_MAX. Operands stream in one beat per handshake (column t of A and
// row t of B); the engine skews them internally, lets the wavefront flush
// through the grid, then drains the tile one row at a time.
//
// Build option:
//   SYSTOLIC_SIGNED_EN  defined   -> two's-complement operands, sign-extended
//                                    products, signed ACCW-bit results
//                       undefined -> unsigned operands and results
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset; aborts any job in flight
//   start      job request, sampled only while idle
//   n_len      inner dimension, sampled with start, clamped to N_MAX
//   busy       high from the cycle after start acceptance until done
//   in_valid   operand beat valid
//   in_ready   engine is accepting operand beats (LOAD only)
//   a_col[i]   beat t: A[i][t], feeds array row i
//   b_row[j]   beat t: B[t][j], feeds array column j
//   out_valid  result row available
//   out_ready  consumer accepts the result row
//   out_row[j] result element (out_idx, j)
//   out_idx    row index of out_row
//   done       one-cycle pulse after the last row is accepted
// -----------------------------------------------------------------------------
module systolic_gemm_engine #(
    parameter int k     = 8,
    parameter int R     = 4,
    parameter int C     = 4,
    parameter int N_MAX = 16,
    parameter int ACCW  = 2 * k + $clog2(N_MAX)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(N_MAX+1)-1:0]        n_len,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [k-1:0]                      a_col [0:R-1],
    input  logic [k-1:0]                      b_row [0:C-1],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ACCW-1:0]                   out_row [0:C-1],
    output logic [((R > 1) ? $clog2(R) : 1)-1:0] out_idx,
    output logic                              done
);

    localparam int NW        = $clog2(N_MAX + 1);
    localparam int IW        = (R > 1) ? $clog2(R) : 1;
    localparam int FLUSH_LEN = R + C - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    // Full-precision product extended to the accumulator width.
    function automatic logic [ACCW-1:0] mac_prod(input logic [k-1:0] a, input logic [k-1:0] b);
        logic [2*k-1:0] p;
`ifdef SYSTOLIC_SIGNED_EN
        logic signed [2*k-1:0] ps;
        ps = (2*k)'($signed(a)) * (2*k)'($signed(b));
        p  = ps;
        return ACCW'($signed(p));
`else
        p = (2*k)'(a) * (2*k)'(b);
        return ACCW'(p);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [NW-1:0]   n_eff_q, n_eff_d;
    logic [NW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_idx_q, out_idx_d;
    logic [ACCW-1:0] out_row_q [0:C-1];
    logic [ACCW-1:0] out_row_d [0:C-1];
    logic            done_q, done_d;

    logic            clr;      // start accepted: wipe skew, pipe and accumulators
    logic            beat;     // operand beat accepted this cycle
    logic            acc_en;   // accumulators only move while data can be in flight
    logic [NW-1:0]   n_clamped;
    logic [IW-1:0]   next_idx;

    logic [ACCW-1:0] acc_w [0:R-1][0:C-1];

    assign beat      = in_valid && in_ready_q;
    assign acc_en    = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign n_clamped = (n_len > NW'(N_MAX)) ? NW'(N_MAX) : n_len;
    assign next_idx  = out_idx_q + IW'(1);

    always_comb begin
        state_d     = state_q;
        n_eff_d     = n_eff_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_row_d   = out_row_q;
        done_d      = 1'b0;
        clr         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr         = 1'b1;
                    n_eff_d     = n_clamped;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    busy_d      = 1'b1;
                    if (n_clamped != '0) begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d    = S_FLUSH;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + NW'(1);
                    if (beat_cnt_q + NW'(1) == n_eff_q) begin
                        state_d     = S_FLUSH;
                        in_ready_d  = 1'b0;
                        flush_cnt_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                // R+C-1 cycles lets the last beat reach cell (R-1, C-1).
                if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                    state_d     = S_DRAIN;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    for (int j = 0; j < C; j++) out_row_d[j] = acc_w[0][j];
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == IW'(R - 1)) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        for (int j = 0; j < C; j++) out_row_d[j] = '0;
                    end else begin
                        out_idx_d = next_idx;
                        for (int j = 0; j < C; j++) out_row_d[j] = acc_w[next_idx][j];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_eff_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
            for (int j = 0; j < C; j++) out_row_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            n_eff_q     <= n_eff_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            for (int j = 0; j < C; j++) out_row_q[j] <= out_row_d[j];
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_row   = out_row_q;
    assign done      = done_q;

    // ------------------------------------------------------------------
    // Input skew: row i delayed by i stages, column j by j stages. Cycles
    // without an accepted beat inject zeros so the wavefront stays aligned.
    // ------------------------------------------------------------------
    logic [k-1:0] a_feed [0:R-1];
    logic [k-1:0] b_feed [0:C-1];

    genvar gi, gj;
    generate
        for (gi = 0; gi < R; gi++) begin : g_a_skew
            logic [k-1:0] a_inj;
            assign a_inj = beat ? a_col[gi] : '0;
            if (gi == 0) begin : g_direct
                assign a_feed[gi] = a_inj;
            end else begin : g_delay
                logic [k-1:0] sr_q [0:gi-1];
                logic [k-1:0] sr_d [0:gi-1];
                always_comb begin
                    sr_d[0] = clr ? '0 : a_inj;
                    for (int s = 1; s < gi; s++) sr_d[s] = clr ? '0 : sr_q[s-1];
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int s = 0; s < gi; s++) sr_q[s] <= '0;
                    end else begin
                        for (int s = 0; s < gi; s++) sr_q[s] <= sr_d[s];
                    end
                end
                assign a_feed[gi] = sr_q[gi-1];
            end
        end

        for (gj = 0; gj < C; gj++) begin : g_b_skew
            logic [k-1:0] b_inj;
            assign b_inj = beat ? b_row[gj] : '0;
            if (gj == 0) begin : g_direct
                assign b_feed[gj] = b_inj;
            end else begin : g_delay
                logic [k-1:0] sr_q [0:gj-1];
                logic [k-1:0] sr_d [0:gj-1];
                always_comb begin
                    sr_d[0] = clr ? '0 : b_inj;
                    for (int s = 1; s < gj; s++) sr_d[s] = clr ? '0 : sr_q[s-1];
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int s = 0; s < gj; s++) sr_q[s] <= '0;
                    end else begin
                        for (int s = 0; s < gj; s++) sr_q[s] <= sr_d[s];
                    end
                end
                assign b_feed[gj] = sr_q[gj-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // MAC grid: each cell passes a to the right and b downward through a
    // register and accumulates a*b in place.
    // ------------------------------------------------------------------
    logic [k-1:0] a_out [0:R-1][0:C-1];
    logic [k-1:0] b_out [0:R-1][0:C-1];

    generate
        for (gi = 0; gi < R; gi++) begin : g_row
            for (gj = 0; gj < C; gj++) begin : g_cell
                logic [k-1:0]    a_in, b_in, a_q, a_d, b_q, b_d;
                logic [ACCW-1:0] acc_q, acc_d;

                if (gj == 0) begin : g_a_edge
                    assign a_in = a_feed[gi];
                end else begin : g_a_inner
                    assign a_in = a_out[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign b_in = b_feed[gj];
                end else begin : g_b_inner
                    assign b_in = b_out[gi-1][gj];
                end

                always_comb begin
                    a_d   = clr ? '0 : a_in;
                    b_d   = clr ? '0 : b_in;
                    acc_d = acc_q;
                    if (clr) begin
                        acc_d = '0;
                    end else if (acc_en) begin
                        acc_d = acc_q + mac_prod(a_in, b_in);
                    end
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        acc_q <= '0;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        acc_q <= acc_d;
                    end
                end

                assign a_out[gi][gj] = a_q;
                assign b_out[gi][gj] = b_q;
                assign acc_w[gi][gj] = acc_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_gemm_engine
//
// Directed bench for systolic_gemm_engine (k=8, R=C=4, N_MAX=16, ACCW=20).
// Jobs: identity, bubbled identity with output stall, n_len=0, clamped
// n_len=20, all-max operands (or the signed corner cases when
// SYSTOLIC_SIGNED_EN is defined), and reset in the middle of LOAD.
// -----------------------------------------------------------------------------
module tb_systolic_gemm_engine;

    localparam int K = 8;
    localparam int R = 4;
    localparam int C = 4;
    localparam int N_MAX = 16;
    localparam int ACCW = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [4:0]      n_len = '0;
    logic            busy;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [K-1:0]    a_col [0:R-1];
    logic [K-1:0]    b_row [0:C-1];
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [ACCW-1:0] out_row [0:C-1];
    logic [1:0]      out_idx;
    logic            done;

    systolic_gemm_engine #(
        .k(K), .R(R), .C(C), .N_MAX(N_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_len     (n_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [K-1:0]    av [0:19][0:R-1];
    logic [K-1:0]    bv [0:19][0:C-1];
    logic [ACCW-1:0] exp_row [0:R-1][0:C-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) done_cnt++;
    endtask

    task automatic drive_zero();
        for (int i = 0; i < R; i++) a_col[i] = '0;
        for (int j = 0; j < C; j++) b_row[j] = '0;
    endtask

    // A = I4, B rows {1..4},{5..8},... so the result equals B.
    task automatic set_identity();
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < R; i++) av[t][i] = (t == i) ? 8'd1 : 8'd0;
            for (int j = 0; j < C; j++) bv[t][j] = 8'(4 * t + j + 1);
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) exp_row[i][j] = 20'(4 * i + j + 1);
    endtask

    task automatic set_const(input logic [7:0] a, input logic [7:0] b, input logic [19:0] e);
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < R; i++) av[t][i] = a;
            for (int j = 0; j < C; j++) bv[t][j] = b;
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) exp_row[i][j] = e;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, ".busy"}, 32'(busy), 0);
        check({name, ".in_ready"}, 32'(in_ready), 0);
        check({name, ".out_valid"}, 32'(out_valid), 0);
        check({name, ".out_idx"}, 32'(out_idx), 0);
        check({name, ".done"}, 32'(done), 0);
        for (int j = 0; j < C; j++) check({name, ".out_row"}, 32'(out_row[j]), 0);
    endtask

    // Runs one job from the current (post-edge) time. exp_beats is n_eff.
    task automatic run_job(input string name, input int nl, input bit bubble,
                           input int stall, input int exp_beats);
        int  beats;
        int  lcyc;
        int  rows;
        int  lat;
        int  sel;
        bit  acc;
        start = 1'b1;
        n_len = 5'(nl);
        tick();
        start = 1'b0;
        cyc = 0;
        done_cnt = 0;
        check({name, ".busy_after_start"}, 32'(busy), 1);
        check({name, ".in_ready_after_start"}, 32'(in_ready), 32'(exp_beats > 0));

        beats = 0;
        lcyc = 0;
        while (in_ready && lcyc < 100) begin
            in_valid = bubble ? (lcyc % 2 == 0) : 1'b1;
            sel = (beats < 20) ? beats : 19;
            for (int i = 0; i < R; i++) a_col[i] = av[sel][i];
            for (int j = 0; j < C; j++) b_row[j] = bv[sel][j];
            acc = in_valid;
            tick();
            if (acc) beats++;
            lcyc++;
        end
        check({name, ".beats"}, 32'(beats), 32'(exp_beats));

        // Operand traffic outside LOAD must not reach the array.
        in_valid = 1'b1;
        for (int i = 0; i < R; i++) a_col[i] = 8'hFF;
        for (int j = 0; j < C; j++) b_row[j] = 8'hFF;
        while (!out_valid && cyc < 200) tick();
        lat = cyc;
        check({name, ".in_ready_off"}, 32'(in_ready), 0);
        check({name, ".out_valid_seen"}, 32'(out_valid), 1);
        if (!bubble) check({name, ".latency"}, 32'(lat), 32'(exp_beats + R + C - 1));
        in_valid = 1'b0;
        drive_zero();

        if (stall > 0) begin
            out_ready = 1'b0;
            start = 1'b1;
            n_len = 5'd3;
            for (int s = 0; s < stall; s++) begin
                tick();
                start = 1'b0;
                check({name, ".stall_valid"}, 32'(out_valid), 1);
                check({name, ".stall_busy"}, 32'(busy), 1);
                check({name, ".stall_idx"}, 32'(out_idx), 0);
                for (int j = 0; j < C; j++)
                    check({name, ".stall_row"}, 32'(out_row[j]), 32'(exp_row[0][j]));
            end
            out_ready = 1'b1;
        end

        rows = 0;
        while (rows < R && cyc < 300) begin
            if (out_valid) begin
                check({name, ".out_idx"}, 32'(out_idx), 32'(rows));
                for (int j = 0; j < C; j++)
                    check({name, ".out_row"}, 32'(out_row[j]), 32'(exp_row[rows][j]));
                rows++;
            end
            tick();
        end
        check({name, ".rows"}, 32'(rows), 32'(R));
        check({name, ".done"}, 32'(done), 1);
        check({name, ".busy_at_done"}, 32'(busy), 0);
        check({name, ".out_valid_at_done"}, 32'(out_valid), 0);
        check({name, ".done_pulses"}, 32'(done_cnt), 1);
        $display("job %s: n_len=%0d beats=%0d latency=%0d done_pulses=%0d",
                 name, nl, beats, lat, done_cnt);
    endtask

    initial begin
        drive_zero();
        #1 rst = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        set_identity();
        run_job("identity", 4, 1'b0, 0, 4);

        run_job("identity_stall", 4, 1'b1, 5, 4);

        set_const(8'd7, 8'd9, 20'd0);
        run_job("n_zero", 0, 1'b0, 0, 0);

        set_const(8'd1, 8'd1, 20'd16);
        run_job("n_clamp", 20, 1'b0, 0, 16);

`ifdef SYSTOLIC_SIGNED_EN
        set_const(8'h80, 8'h80, 20'd262144);
        run_job("signed_neg_neg", 16, 1'b0, 0, 16);
        set_const(8'h80, 8'h7F, 20'(-260096));
        run_job("signed_neg_pos", 16, 1'b0, 0, 16);
`else
        set_const(8'd255, 8'd255, 20'd1040400);
        run_job("unsigned_max", 16, 1'b0, 0, 16);
`endif

        // Reset two beats into LOAD, then an identity job must be clean.
        set_identity();
        start = 1'b1;
        n_len = 5'd4;
        tick();
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1;
            for (int i = 0; i < R; i++) a_col[i] = av[t][i];
            for (int j = 0; j < C; j++) b_row[j] = bv[t][j];
            tick();
        end
        in_valid = 1'b0;
        drive_zero();
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        tick();
        rst = 1'b1;
        tick();
        run_job("identity_after_reset", 4, 1'b0, 0, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
